// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Decode/writeback bundle for the scoreboarded register file.
//               The master drives read addresses, reservations and writeback;
//               the slave (register file) returns operands, busy flags and
//               the busy count.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   logic [AW-1:0]   rd_addr1;
   logic [AW-1:0]   rd_addr2;
   logic [XLEN-1:0] rd_data1;
   logic [XLEN-1:0] rd_data2;
   logic            rd_busy1;
   logic            rd_busy2;
   logic            rsv_en;
   logic [AW-1:0]   rsv_addr;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [AW:0]     busy_count;

   modport master (
      output rd_addr1, rd_addr2, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
      input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_count
   );

   modport slave (
      input  rd_addr1, rd_addr2, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
      output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_count
   );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Integer register file with per-register busy scoreboard and
//               optional same-cycle write-to-read forwarding. x0 is
//               hardwired to zero and can never be reserved.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_sb_if.slave  bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [AW:0]      busy_count_q;
   logic [AW:0]      busy_count_d;
   logic             wr_hit;
   logic             rsv_hit;
   logic             cnt_inc;
   logic             cnt_dec;
   logic             fwd1;
   logic             fwd2;

   // Next busy set and busy count; a reservation wins over a same-address write.
   always_comb begin
      wr_hit  = bus.wr_en  && (bus.wr_addr  != '0);
      rsv_hit = bus.rsv_en && (bus.rsv_addr != '0);
      busy_d  = busy_q;
      if (wr_hit) begin
         busy_d[bus.wr_addr] = 1'b0;
      end
      if (rsv_hit) begin
         busy_d[bus.rsv_addr] = 1'b1;
      end
      // Only genuine 0->1 and 1->0 transitions move the count.
      cnt_inc = rsv_hit && !busy_q[bus.rsv_addr];
      cnt_dec = wr_hit && busy_q[bus.wr_addr]
                && !(rsv_hit && (bus.rsv_addr == bus.wr_addr));
      busy_count_d = busy_count_q;
      if (cnt_inc && !cnt_dec) begin
         busy_count_d = busy_count_q + {{AW{1'b0}}, 1'b1};
      end else if (cnt_dec && !cnt_inc) begin
         busy_count_d = busy_count_q - {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage, busy flags and count; reset discards all data and reservations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         if (wr_hit) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
         end
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   generate
      if (BYPASS != 0) begin : g_bypass
         assign fwd1 = bus.wr_en && (bus.wr_addr == bus.rd_addr1);
         assign fwd2 = bus.wr_en && (bus.wr_addr == bus.rd_addr2);
      end else begin : g_no_bypass
         assign fwd1 = 1'b0;
         assign fwd2 = 1'b0;
      end
   endgenerate

   // Combinational read ports; x0 always reads zero and never busy.
   always_comb begin
      if (bus.rd_addr1 == '0) begin
         bus.rd_data1 = '0;
      end else if (fwd1) begin
         bus.rd_data1 = bus.wr_data;
      end else begin
         bus.rd_data1 = regs_q[bus.rd_addr1];
      end
      if (bus.rd_addr2 == '0) begin
         bus.rd_data2 = '0;
      end else if (fwd2) begin
         bus.rd_data2 = bus.wr_data;
      end else begin
         bus.rd_data2 = regs_q[bus.rd_addr2];
      end
      bus.rd_busy1   = busy_q[bus.rd_addr1] && !fwd1;
      bus.rd_busy2   = busy_q[bus.rd_addr2] && !fwd2;
      bus.busy_count = busy_count_q;
   end
endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb; one instance with
//               forwarding, one without, both driven by the same stimulus
//               and checked against a behavioural scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   typedef struct packed {
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic            b1;
      logic            b2;
      logic [AW:0]     cnt;
   } snap_t;

   typedef struct packed {
      snap_t byp;
      snap_t nob;
   } pair_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW-1:0]   rd_addr1 = '0;
   logic [AW-1:0]   rd_addr2 = '0;
   logic            rsv_en = 1'b0;
   logic [AW-1:0]   rsv_addr = '0;
   logic            wr_en = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [XLEN-1:0] wr_data = '0;

   always #5 clk = ~clk;

   regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus_b ();
   regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus_n ();

   assign bus_b.rd_addr1 = rd_addr1;
   assign bus_b.rd_addr2 = rd_addr2;
   assign bus_b.rsv_en   = rsv_en;
   assign bus_b.rsv_addr = rsv_addr;
   assign bus_b.wr_en    = wr_en;
   assign bus_b.wr_addr  = wr_addr;
   assign bus_b.wr_data  = wr_data;
   assign bus_n.rd_addr1 = rd_addr1;
   assign bus_n.rd_addr2 = rd_addr2;
   assign bus_n.rsv_en   = rsv_en;
   assign bus_n.rsv_addr = rsv_addr;
   assign bus_n.wr_en    = wr_en;
   assign bus_n.wr_addr  = wr_addr;
   assign bus_n.wr_data  = wr_data;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
   );
   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .bus(bus_n.slave)
   );

   // Behavioural model state
   logic [XLEN-1:0]  m_regs [NREGS];
   logic [NREGS-1:0] m_busy;
   int               m_cnt;

   pair_t exp_q[$];
   pair_t e;
   pair_t o;
   int    errors = 0;
   int    checks = 0;

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_busy = '0;
      m_cnt  = 0;
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (wr_en && wr_addr != 0) begin
         m_regs[wr_addr] = wr_data;
         m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      m_cnt = $countones(m_busy);
   endtask

   function automatic snap_t model_snap(input bit byp);
      snap_t s;
      logic  f1;
      logic  f2;
      f1 = byp && wr_en && (wr_addr == rd_addr1);
      f2 = byp && wr_en && (wr_addr == rd_addr2);
      if (rd_addr1 == 0)  s.d1 = '0;
      else if (f1)        s.d1 = wr_data;
      else                s.d1 = m_regs[rd_addr1];
      if (rd_addr2 == 0)  s.d2 = '0;
      else if (f2)        s.d2 = wr_data;
      else                s.d2 = m_regs[rd_addr2];
      s.b1  = m_busy[rd_addr1] && !f1;
      s.b2  = m_busy[rd_addr2] && !f2;
      s.cnt = (AW+1)'(m_cnt);
      return s;
   endfunction

   function automatic pair_t observe();
      pair_t p;
      p.byp = {bus_b.rd_data1, bus_b.rd_data2, bus_b.rd_busy1, bus_b.rd_busy2, bus_b.busy_count};
      p.nob = {bus_n.rd_data1, bus_n.rd_data2, bus_n.rd_busy1, bus_n.rd_busy2, bus_n.busy_count};
      return p;
   endfunction

   task automatic push_exp();
      exp_q.push_back({model_snap(1'b1), model_snap(1'b0)});
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      rsv_en = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_state: got %h want %h", o, e); end
      tick();
      wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
      rsv_en = 1'b1; rsv_addr = 6;
      rd_addr1 = 5; rd_addr2 = 6;
      tick();
      idle();
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL pre_reset: got %h want %h", o, e); end
      #1 rst_n = 1'b0;
      model_reset();
      push_exp();
      #1;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL async_reset: got %h want %h", o, e); end
      checks++;
      if ({bus_b.rd_data1, bus_b.rd_busy2, bus_b.busy_count} !== '0) begin
         errors++;
         $display("FAIL async_reset_vals: got d1=%h b2=%b cnt=%0d want 0", bus_b.rd_data1, bus_b.rd_busy2, bus_b.busy_count);
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_x0();
      wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
      rsv_en = 1'b1; rsv_addr = 0;
      rd_addr1 = 0; rd_addr2 = 0;
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL x0_same_cycle: got %h want %h", o, e); end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if ({bus_b.rd_data1, bus_b.rd_busy1, bus_b.busy_count, bus_n.rd_data2, bus_n.busy_count} !== '0) begin
         errors++;
         $display("FAIL x0_after: got d1=%h b1=%b cnt=%0d want 0", bus_b.rd_data1, bus_b.rd_busy1, bus_b.busy_count);
      end
   endtask

   task automatic test_bypass();
      tick();
      wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55;
      tick();
      wr_data = 32'h1234; rd_addr1 = 3; rd_addr2 = 0;
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL bypass_same_cycle: got %h want %h", o, e); end
      checks++;
      if (bus_b.rd_data1 !== 32'h1234 || bus_n.rd_data1 !== 32'h55) begin
         errors++;
         $display("FAIL bypass_values: got byp=%h nob=%h want 1234/55", bus_b.rd_data1, bus_n.rd_data1);
      end
      tick();
      idle();
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL bypass_next_cycle: got %h want %h", o, e); end
      checks++;
      if (bus_n.rd_data1 !== 32'h1234) begin
         errors++; $display("FAIL nobypass_next: got %h want 1234", bus_n.rd_data1);
      end
   endtask

   task automatic test_scoreboard();
      tick();
      rsv_en = 1'b1; rsv_addr = 7; rd_addr1 = 7; rd_addr2 = 0;
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL rsv_same_cycle: got %h want %h", o, e); end
      tick();
      idle();
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL rsv_visible: got %h want %h", o, e); end
      checks++;
      if (bus_b.rd_busy1 !== 1'b1 || bus_b.busy_count !== 6'd1) begin
         errors++; $display("FAIL rsv_values: got b1=%b cnt=%0d want 1/1", bus_b.rd_busy1, bus_b.busy_count);
      end
      tick();
      wr_en = 1'b1; wr_addr = 7; wr_data = 32'd42; rd_addr2 = 7;
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL wb_same_cycle: got %h want %h", o, e); end
      checks++;
      if (bus_b.rd_busy2 !== 1'b0 || bus_b.rd_data2 !== 32'd42 || bus_n.rd_busy2 !== 1'b1) begin
         errors++; $display("FAIL wb_values: got b2=%b d2=%0d nob_b2=%b want 0/42/1", bus_b.rd_busy2, bus_b.rd_data2, bus_n.rd_busy2);
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (bus_b.busy_count !== 6'd0 || bus_n.busy_count !== 6'd0) begin
         errors++; $display("FAIL wb_count: got %0d/%0d want 0", bus_b.busy_count, bus_n.busy_count);
      end
   endtask

   task automatic test_simultaneous();
      tick();
      rsv_en = 1'b1; rsv_addr = 9;
      tick();
      wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99; rd_addr1 = 9;
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL simul_same_cycle: got %h want %h", o, e); end
      tick();
      idle();
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL simul_after: got %h want %h", o, e); end
      checks++;
      if (bus_b.rd_data1 !== 32'h99 || bus_b.rd_busy1 !== 1'b1 || bus_b.busy_count !== 6'd1) begin
         errors++; $display("FAIL simul_values: got d=%h b=%b cnt=%0d want 99/1/1", bus_b.rd_data1, bus_b.rd_busy1, bus_b.busy_count);
      end
      tick();
      wr_en = 1'b1; wr_addr = 9; wr_data = 32'h9A;
      tick();
      idle();
   endtask

   task automatic test_saturation();
      for (int i = 1; i < NREGS; i++) begin
         rsv_en = 1'b1; rsv_addr = AW'(i);
         tick();
      end
      idle();
      @(negedge clk);
      checks++;
      if (bus_b.busy_count !== 6'(NREGS-1) || bus_n.busy_count !== 6'(NREGS-1)) begin
         errors++; $display("FAIL sat_full: got %0d/%0d want %0d", bus_b.busy_count, bus_n.busy_count, NREGS-1);
      end
      rsv_en = 1'b1; rsv_addr = 1;
      tick();
      idle();
      push_exp();
      @(negedge clk);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL sat_rereserve: got %h want %h", o, e); end
      wr_en = 1'b1; wr_addr = 2; wr_data = 32'h2;
      tick();
      wr_addr = 1; wr_data = 32'h1; rsv_en = 1'b1; rsv_addr = 2;
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (bus_b.busy_count !== 6'(NREGS-2)) begin
         errors++; $display("FAIL sat_net_zero: got %0d want %0d", bus_b.busy_count, NREGS-2);
      end
      for (int i = 2; i < NREGS; i++) begin
         tick();
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'(i * 3);
         rd_addr1 = AW'(i); rd_addr2 = AW'(i - 1);
         push_exp();
         @(negedge clk);
         e = exp_q.pop_front(); o = observe(); checks++;
         if (o !== e) begin errors++; $display("FAIL sat_drain x%0d: got %h want %h", i, o, e); end
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (bus_b.busy_count !== 6'd0 || bus_n.busy_count !== 6'd0) begin
         errors++; $display("FAIL sat_empty: got %0d/%0d want 0", bus_b.busy_count, bus_n.busy_count);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 300; n++) begin
         tick();
         wr_en    = ($urandom_range(0, 2) != 0);
         wr_addr  = AW'($urandom_range(0, NREGS-1));
         wr_data  = $urandom;
         rsv_en   = ($urandom_range(0, 2) != 0);
         rsv_addr = ($urandom_range(0, 4) == 0) ? wr_addr : AW'($urandom_range(0, NREGS-1));
         rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NREGS-1));
         rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : AW'($urandom_range(0, NREGS-1));
         push_exp();
         @(negedge clk);
         e = exp_q.pop_front(); o = observe(); checks++;
         if (o !== e) begin errors++; $display("FAIL random cycle %0d: got %h want %h", n, o, e); end
      end
      tick();
      idle();
   endtask

   initial begin
      test_reset();
      test_x0();
      test_bypass();
      test_scoreboard();
      test_simultaneous();
      test_saturation();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
